// File: rtl/maze_pixel_renderer.sv
// Tile-based maze renderer: 40x30 tiles of 16x16 pixels, two-tick pixel pipeline, frame-synchronised player position.
// Optional feature macro MAZE_RENDER_LOST_OVERLAY_EN: floor tiles turn red while lost is high.
module maze_pixel_renderer #(
  parameter int H_OFS = 144,
  parameter int V_OFS = 35
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_en,
  input  logic        bright,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic [7:0]  player_x_pos,
  input  logic [7:0]  player_y_pos,
  input  logic        pos_valid,
  output logic        pos_ready,
  input  logic        lost,
  output logic [11:0] rgb,
  output logic        frame_start
);

  logic [5:0]  tile_x_d;
  logic [5:0]  tile_y_d;
  logic        commit_d;
  logic        is_wall_d;
  logic        is_player_d;
  logic [11:0] floor_d;
  logic [11:0] colour_d;
  logic [7:0]  pend_x_d;
  logic [7:0]  pend_y_d;

  logic [5:0]  tx_q;
  logic [5:0]  ty_q;
  logic        bright_q;
  logic [11:0] rgb_q;
  logic        frame_start_q;
  logic [7:0]  disp_x_q;
  logic [7:0]  disp_y_q;
  logic [7:0]  pend_x_q;
  logic [7:0]  pend_y_q;
  logic        pend_full_q;

  // Tile coordinates drop the 4 in-tile pixel bits of the offset-corrected counters.
  assign tile_x_d = 6'((hCount - 10'(H_OFS)) >> 4);
  assign tile_y_d = 6'((vCount - 10'(V_OFS)) >> 4);
  assign commit_d = pix_en && (hCount == 10'd0) && (vCount == 10'd0);
  assign pend_x_d = (player_x_pos > 8'd39) ? 8'd39 : player_x_pos;
  assign pend_y_d = (player_y_pos > 8'd29) ? 8'd29 : player_y_pos;

`ifndef MAZE_RENDER_LOST_OVERLAY_EN
  logic unused_lost_d;
  assign unused_lost_d = lost;
`endif

  // Stage-2 colour from the registered tile and the displayed player position.
  always_comb begin
    floor_d = 12'h000;
`ifdef MAZE_RENDER_LOST_OVERLAY_EN
    if (lost) begin
      floor_d = 12'hF00;
    end else begin
      floor_d = 12'h000;
    end
`endif
    is_wall_d = (tx_q == 6'd0) || (tx_q == 6'd39) || (ty_q == 6'd0) || (ty_q == 6'd29) ||
                ((tx_q[1:0] == 2'd2) && (ty_q[2:0] != 3'd3));
    is_player_d = ({2'b00, tx_q} == disp_x_q) && ({2'b00, ty_q} == disp_y_q);
    if (!bright_q) begin
      colour_d = 12'h000;
    end else if (is_player_d) begin
      colour_d = 12'hFF0;
    end else if (is_wall_d) begin
      colour_d = 12'h00F;
    end else begin
      colour_d = floor_d;
    end
  end

  // Pixel pipeline, frame-boundary commit and single-entry position buffer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_q          <= 6'd0;
      ty_q          <= 6'd0;
      bright_q      <= 1'b0;
      rgb_q         <= 12'h000;
      frame_start_q <= 1'b0;
      disp_x_q      <= 8'd1;
      disp_y_q      <= 8'd1;
      pend_x_q      <= 8'd0;
      pend_y_q      <= 8'd0;
      pend_full_q   <= 1'b0;
    end else begin
      frame_start_q <= commit_d;
      if (pix_en) begin
        tx_q     <= tile_x_d;
        ty_q     <= tile_y_d;
        bright_q <= bright;
        rgb_q    <= colour_d;
      end
      // Commit wins; a full buffer also holds pos_ready low, so no capture collides with it.
      if (commit_d && pend_full_q) begin
        disp_x_q    <= pend_x_q;
        disp_y_q    <= pend_y_q;
        pend_full_q <= 1'b0;
      end else if (pos_valid && !pend_full_q) begin
        pend_x_q    <= pend_x_d;
        pend_y_q    <= pend_y_d;
        pend_full_q <= 1'b1;
      end
    end
  end

  assign pos_ready   = !pend_full_q;
  assign rgb         = rgb_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_maze_pixel_renderer.sv
// Randomised and directed bench for maze_pixel_renderer against a pixel-level reference model.
module tb_maze_pixel_renderer;

`ifdef MAZE_RENDER_LOST_OVERLAY_EN
  localparam bit OVERLAY = 1'b1;
`else
  localparam bit OVERLAY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_en = 1'b0;
  logic        bright = 1'b0;
  logic [9:0]  hCount = 10'd0;
  logic [9:0]  vCount = 10'd0;
  logic [7:0]  player_x_pos = 8'd0;
  logic [7:0]  player_y_pos = 8'd0;
  logic        pos_valid = 1'b0;
  logic        pos_ready;
  logic        lost = 1'b0;
  logic [11:0] rgb;
  logic        frame_start;

  int n_total = 0;
  int n_bad = 0;

  // Reference state: displayed/pending positions and the last ticked raw pixel.
  bit          m_known = 1'b0;
  int          m_disp_x, m_disp_y, m_pend_x, m_pend_y;
  bit          m_pend_full;
  int          m_s1_h, m_s1_v;
  bit          m_s1_b;
  logic [11:0] m_rgb;
  bit          m_fs;

  maze_pixel_renderer dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .bright(bright),
    .hCount(hCount), .vCount(vCount), .player_x_pos(player_x_pos),
    .player_y_pos(player_y_pos), .pos_valid(pos_valid), .pos_ready(pos_ready),
    .lost(lost), .rgb(rgb), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_colour(int h, int v, bit b, int dx, int dy, bit lo);
    int tx, ty;
    bit wall;
    if (!b) return 12'h000;
    tx = ((h - 144) & 1023) / 16;
    ty = ((v - 35) & 1023) / 16;
    if (tx == dx && ty == dy) return 12'hFF0;
    wall = (tx == 0) || (tx == 39) || (ty == 0) || (ty == 29) || ((tx % 4 == 2) && (ty % 8 != 3));
    if (wall) return 12'h00F;
    if (lo && OVERLAY) return 12'hF00;
    return 12'h000;
  endfunction

  // Advance the reference by one clk edge using the inputs currently applied.
  task automatic model_edge();
    bit commit;
    if (!reset_n) begin
      m_rgb = 12'h000; m_fs = 1'b0; m_pend_full = 1'b0;
      m_disp_x = 1; m_disp_y = 1; m_pend_x = 0; m_pend_y = 0;
      m_s1_h = 144; m_s1_v = 35; m_s1_b = 1'b0;
      m_known = 1'b1;
      return;
    end
    commit = pix_en && (hCount == 10'd0) && (vCount == 10'd0);
    if (pix_en) begin
      m_rgb  = ref_colour(m_s1_h, m_s1_v, m_s1_b, m_disp_x, m_disp_y, lost);
      m_s1_h = int'(hCount); m_s1_v = int'(vCount); m_s1_b = bright;
    end
    m_fs = commit;
    if (commit && m_pend_full) begin
      m_disp_x = m_pend_x; m_disp_y = m_pend_y; m_pend_full = 1'b0;
    end else if (pos_valid && !m_pend_full) begin
      m_pend_x = (player_x_pos > 8'd39) ? 39 : int'(player_x_pos);
      m_pend_y = (player_y_pos > 8'd29) ? 29 : int'(player_y_pos);
      m_pend_full = 1'b1;
    end
  endtask

  task automatic cyc();
    if (m_known) check_val("pos_ready", 32'(pos_ready), 32'(!m_pend_full));
    model_edge();
    @(posedge clk);
    #1;
    check_val("rgb", 32'(rgb), 32'(m_rgb));
    check_val("frame_start", 32'(frame_start), 32'(m_fs));
  endtask

  task automatic set_tile(input int tx, input int ty, input bit b);
    hCount = 10'(144 + tx * 16 + int'($urandom_range(0, 15)));
    vCount = 10'(35 + ty * 16 + int'($urandom_range(0, 15)));
    bright = b;
  endtask

  task automatic tick();
    pix_en = 1'b1;
    cyc();
    pix_en = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic render(input string tag, input int tx, input int ty, input bit b, input logic [11:0] exp);
    set_tile(tx, ty, b);
    tick();
    set_tile(5, 5, 1'b0);
    tick();
    check_val(tag, 32'(rgb), 32'(exp));
  endtask

  task automatic offer(input int x, input int y);
    pos_valid = 1'b1;
    player_x_pos = 8'(x);
    player_y_pos = 8'(y);
    cyc();
    pos_valid = 1'b0;
  endtask

  task automatic commit_tick();
    hCount = 10'd0; vCount = 10'd0; bright = 1'b0; pix_en = 1'b1;
    cyc();
    check_val("fs_pulse", 32'(frame_start), 32'd1);
    pix_en = 1'b0;
    cyc();
    check_val("fs_low", 32'(frame_start), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc();
    check_val("rst_rgb", 32'(rgb), 32'd0);
    check_val("rst_ready", 32'(pos_ready), 32'd1);
    check_val("rst_fs", 32'(frame_start), 32'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    int tx, ty;
    #2;
    do_reset();
    cyc();
    check_val("ready_after_rst", 32'(pos_ready), 32'd1);

    render("player_1_1", 1, 1, 1'b1, 12'hFF0);
    render("wall_2_0", 2, 0, 1'b1, 12'h00F);
    render("floor_5_5", 5, 5, 1'b1, 12'h000);
    render("dark_1_1", 1, 1, 1'b0, 12'h000);
    render("wall_39_10", 39, 10, 1'b1, 12'h00F);
    render("floor_row3", 6, 3, 1'b1, 12'h000);

    offer(10, 7);
    check_val("ready_low", 32'(pos_ready), 32'd0);
    render("hold_1_1", 1, 1, 1'b1, 12'hFF0);
    render("pre_10_7", 10, 7, 1'b1, 12'h00F);
    commit_tick();
    render("post_10_7", 10, 7, 1'b1, 12'hFF0);
    render("post_1_1", 1, 1, 1'b1, 12'h000);

    offer(3, 4);
    pos_valid = 1'b1; player_x_pos = 8'd200; player_y_pos = 8'd255;
    repeat (3) begin
      cyc();
      check_val("stalled", 32'(pos_ready), 32'd0);
    end
    hCount = 10'd0; vCount = 10'd0; pix_en = 1'b1;
    cyc();
    check_val("commit_fs", 32'(frame_start), 32'd1);
    check_val("ready_after_commit", 32'(pos_ready), 32'd1);
    pix_en = 1'b0;
    cyc();
    check_val("second_taken", 32'(pos_ready), 32'd0);
    pos_valid = 1'b0;
    render("disp_3_4", 3, 4, 1'b1, 12'hFF0);
    commit_tick();
    render("clamp_39_29", 39, 29, 1'b1, 12'hFF0);

    lost = 1'b1;
    render("lost_floor", 5, 5, 1'b1, OVERLAY ? 12'hF00 : 12'h000);
    render("lost_wall", 2, 0, 1'b1, 12'h00F);
    lost = 1'b0;

    offer(20, 20);
    set_tile(39, 29, 1'b1);
    pix_en = 1'b1; cyc(); cyc(); pix_en = 1'b0;
    do_reset();
    cyc();
    check_val("rst_black", 32'(rgb), 32'd0);
    commit_tick();
    render("rst_disp_1_1", 1, 1, 1'b1, 12'hFF0);
    render("rst_pend_gone", 20, 20, 1'b1, 12'h000);

    // Random traffic: pixels biased onto the player/pending tiles plus occasional frame ticks and resets.
    for (int i = 0; i < 6000; i++) begin
      reset_n = ($urandom_range(0, 799) != 0);
      pix_en = ($urandom_range(0, 3) == 0);
      bright = ($urandom_range(0, 3) != 0);
      lost = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 9))
        0: begin hCount = 10'd0; vCount = 10'd0; end
        1: begin hCount = 10'($urandom); vCount = 10'($urandom); end
        2, 3: set_tile(m_disp_x, m_disp_y, bright);
        4: set_tile(m_pend_x, m_pend_y, bright);
        default: begin
          tx = int'($urandom_range(0, 39)); ty = int'($urandom_range(0, 29));
          set_tile(tx, ty, bright);
        end
      endcase
      pos_valid = ($urandom_range(0, 7) == 0);
      player_x_pos = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 45)) : 8'($urandom);
      player_y_pos = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 35)) : 8'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
